// File: rtl/fazyrv_pkg.sv
// Shared types and helpers for the chunk-serial FazyRV datapath stages.
package fazyrv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWaitRes,
        StDone
    } rf_seq_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic int unsigned chunks(input int unsigned chunksize);
        return 32 / chunksize;
    endfunction

endpackage

// File: rtl/fazyrv_chunk_cnt.sv
// Chunk position counter: counts enabled cycles modulo N and flags first/last chunk.
module fazyrv_chunk_cnt #(
    parameter int unsigned N = 16
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic clr_i,
    input  logic en_i,
    output logic first_o,
    output logic last_o
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            // Wrap explicitly so the count never leaves 0..N-1.
            r_cnt <= last_o ? '0 : r_cnt + 1'b1;
        end
    end

    assign first_o = (r_cnt == '0);
    assign last_o  = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/fazyrv_rf_seq.sv
// Register-file chunk sequencer: operand shift strobes, rd write enables and
// LSB/MSB chunk flags, plus a destination-only result phase for ccx instructions.
module fazyrv_rf_seq
    import fazyrv_pkg::*;
#(
    parameter int unsigned CHUNKSIZE = 2
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       start_i,
    output logic       ready_o,
    input  logic       ccx_i,
    input  logic       wr_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       stall_i,
    input  logic       res_vld_i,
    output logic [4:0] rs1_o,
    output logic [4:0] rs2_o,
    output logic [4:0] rd_o,
    output logic       shft_o,
    output logic       shft_rd_o,
    output logic       we_o,
    output logic       lsb_o,
    output logic       msb_o,
    output logic       done_o
);

    localparam int unsigned N = chunks(CHUNKSIZE);

    if ((CHUNKSIZE != 1) && (CHUNKSIZE != 2) && (CHUNKSIZE != 4) && (CHUNKSIZE != 8))
    begin : g_bad_chunksize
        $error("fazyrv_rf_seq: CHUNKSIZE must be 1, 2, 4 or 8");
    end

    rf_seq_state_t r_state;
    logic          r_ccx;
    logic          r_wr;
    logic [4:0]    r_rs1;
    logic [4:0]    r_rs2;
    logic [4:0]    r_rd;

    logic w_accept;
    logic w_run;
    logic w_wait;
    logic w_strobe;
    logic w_rd_live;
    logic w_first;
    logic w_last;

    assign w_accept  = start_i & (r_state == StIdle);
    assign w_run     = (r_state == StRun);
    assign w_wait    = (r_state == StWaitRes);
    assign w_rd_live = r_wr & (r_rd != REG_ZERO);

    fazyrv_chunk_cnt #(
        .N (N)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .clr_i   (w_accept),
        .en_i    (w_strobe),
        .first_o (w_first),
        .last_o  (w_last)
    );

    // Operand phase writes rd directly only for non-ccx ops; ccx results
    // arrive later and are written during the destination-only phase.
    assign shft_o    = w_run & ~stall_i;
    assign shft_rd_o = w_wait & res_vld_i;
    assign w_strobe  = shft_o | shft_rd_o;
    assign we_o      = (shft_o & w_rd_live & ~r_ccx) | (shft_rd_o & w_rd_live);
    assign lsb_o     = w_strobe & w_first;
    assign msb_o     = w_strobe & w_last;

    assign ready_o = (r_state == StIdle);
    assign done_o  = (r_state == StDone);
    assign rs1_o   = r_rs1;
    assign rs2_o   = r_rs2;
    assign rd_o    = r_rd;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= StIdle;
            r_ccx   <= 1'b0;
            r_wr    <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_ccx   <= ccx_i;
                        r_wr    <= wr_i;
                        r_rs1   <= rs1_i;
                        r_rs2   <= rs2_i;
                        r_rd    <= rd_i;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (shft_o && w_last) begin
                        r_state <= r_ccx ? StWaitRes : StDone;
                    end
                end
                StWaitRes: begin
                    if (shft_rd_o && w_last) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Directed bench for fazyrv_rf_seq with CHUNKSIZE=2 (16 chunks per word).
module tb_fazyrv_rf_seq;

    logic       clk;
    logic       rst_in;
    logic       start_i;
    logic       ready_o;
    logic       ccx_i;
    logic       wr_i;
    logic [4:0] rs1_i;
    logic [4:0] rs2_i;
    logic [4:0] rd_i;
    logic       stall_i;
    logic       res_vld_i;
    logic [4:0] rs1_o;
    logic [4:0] rs2_o;
    logic [4:0] rd_o;
    logic       shft_o;
    logic       shft_rd_o;
    logic       we_o;
    logic       lsb_o;
    logic       msb_o;
    logic       done_o;

    int errors;
    int checks;
    int n_shft;
    int n_we;
    int n_lsb;
    int n_msb;

    fazyrv_rf_seq #(
        .CHUNKSIZE (2)
    ) dut (
        .clk_i     (clk),
        .rst_in    (rst_in),
        .start_i   (start_i),
        .ready_o   (ready_o),
        .ccx_i     (ccx_i),
        .wr_i      (wr_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .rd_i      (rd_i),
        .stall_i   (stall_i),
        .res_vld_i (res_vld_i),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .rd_o      (rd_o),
        .shft_o    (shft_o),
        .shft_rd_o (shft_rd_o),
        .we_o      (we_o),
        .lsb_o     (lsb_o),
        .msb_o     (msb_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, sample 1 time unit later.
    task automatic cyc(input logic st, input logic rv, input logic sta);
        @(negedge clk);
        stall_i   = st;
        res_vld_i = rv;
        start_i   = sta;
        #1;
    endtask

    task automatic accept(input logic c, input logic w, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] d);
        @(negedge clk);
        ccx_i     = c;
        wr_i      = w;
        rs1_i     = a1;
        rs2_i     = a2;
        rd_i      = d;
        stall_i   = 1'b0;
        res_vld_i = 1'b0;
        start_i   = 1'b1;
        #1;
        chk("accept_ready", ready_o, 1'b1);
    endtask

    task automatic clr_tally();
        n_shft = 0;
        n_we   = 0;
        n_lsb  = 0;
        n_msb  = 0;
    endtask

    task automatic tally();
        n_shft += int'(shft_o);
        n_we   += int'(we_o);
        n_lsb  += int'(lsb_o);
        n_msb  += int'(msb_o);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_in    = 1'b0;
        start_i   = 1'b0;
        ccx_i     = 1'b0;
        wr_i      = 1'b0;
        rs1_i     = 5'd0;
        rs2_i     = 5'd0;
        rd_i      = 5'd0;
        stall_i   = 1'b0;
        res_vld_i = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_strobes", {shft_o, shft_rd_o, we_o, lsb_o, msb_o, done_o}, 6'b0);
        chk("rst_addr", {rs1_o, rs2_o, rd_o}, 15'd0);
        @(negedge clk);
        rst_in = 1'b1;

        // Plain write-back op: 16 shifts with writes, done at T+17, ready at T+18
        accept(1'b0, 1'b1, 5'd3, 5'd4, 5'd5);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("t1_shft_%0d", k), shft_o, 1'b1);
            chk($sformatf("t1_we_%0d", k), we_o, 1'b1);
            chk($sformatf("t1_lsb_%0d", k), lsb_o, (k == 1) ? 1'b1 : 1'b0);
            chk($sformatf("t1_msb_%0d", k), msb_o, (k == 16) ? 1'b1 : 1'b0);
            chk($sformatf("t1_done_%0d", k), done_o, 1'b0);
        end
        chk("t1_addr", {rs1_o, rs2_o, rd_o}, {5'd3, 5'd4, 5'd5});
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_done", done_o, 1'b1);
        chk("t1_done_noshft", {shft_o, we_o, ready_o}, 3'b000);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_ready", ready_o, 1'b1);
        chk("t1_done_pulse", done_o, 1'b0);

        // rd = x0: shifts happen, no writes
        accept(1'b0, 1'b1, 5'd3, 5'd4, 5'd0);
        clr_tally();
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            tally();
        end
        chk("t2_nshft", n_shft, 16);
        chk("t2_nwe", n_we, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t2_done", done_o, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // Three stall cycles with cnt at 7: done moves to T+20
        accept(1'b0, 1'b1, 5'd3, 5'd4, 5'd5);
        clr_tally();
        for (int k = 1; k <= 19; k++) begin
            cyc((k >= 8 && k <= 10) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            tally();
            if (k >= 8 && k <= 10) begin
                chk($sformatf("t3_stall_%0d", k), {shft_o, we_o, lsb_o, msb_o}, 4'b0);
            end
            if (k == 19) chk("t3_msb_last", msb_o, 1'b1);
        end
        chk("t3_nshft", n_shft, 16);
        chk("t3_nwe", n_we, 16);
        chk("t3_nlsb", n_lsb, 1);
        chk("t3_nmsb", n_msb, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_done", done_o, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // ccx: operand phase ignores res_vld_i, then one rd chunk per valid
        accept(1'b1, 1'b1, 5'd1, 5'd2, 5'd9);
        clr_tally();
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            tally();
            chk($sformatf("t4_op_rd_%0d", k), {shft_rd_o, we_o}, 2'b00);
        end
        chk("t4_op_nshft", n_shft, 16);
        clr_tally();
        for (int j = 0; j < 32; j++) begin
            logic rv;
            rv = (j % 2 == 1) ? 1'b1 : 1'b0;
            cyc(1'b1, rv, 1'b0);
            tally();
            chk($sformatf("t4_res_%0d", j), {shft_o, shft_rd_o, we_o}, {1'b0, rv, rv});
            chk($sformatf("t4_nodone_%0d", j), done_o, 1'b0);
            if (j == 1) chk("t4_lsb", lsb_o, 1'b1);
            if (j == 31) chk("t4_msb", msb_o, 1'b1);
        end
        chk("t4_res_nwe", n_we, 16);
        chk("t4_res_nlsb", n_lsb, 1);
        chk("t4_res_nmsb", n_msb, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_done", done_o, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // start_i while busy is ignored
        accept(1'b0, 1'b1, 5'd3, 5'd4, 5'd5);
        clr_tally();
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) begin
                rs1_i = 5'd20;
                rs2_i = 5'd22;
                rd_i  = 5'd21;
            end
            cyc(1'b0, 1'b0, (k == 4) ? 1'b1 : 1'b0);
            tally();
            if (k == 4) chk("t5_busy_ready", ready_o, 1'b0);
        end
        chk("t5_addr", {rs1_o, rd_o}, {5'd3, 5'd5});
        chk("t5_nshft", n_shft, 16);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_done", done_o, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_ready", ready_o, 1'b1);

        // Async reset at chunk 10, then a fresh full run
        accept(1'b0, 1'b1, 5'd3, 5'd4, 5'd5);
        for (int k = 1; k <= 11; k++) cyc(1'b0, 1'b0, 1'b0);
        chk("t6_pre_rst", {shft_o, we_o, lsb_o}, 3'b110);
        #1;
        rst_in = 1'b0;
        #1;
        chk("t6_rst_strobes", {shft_o, shft_rd_o, we_o, lsb_o, msb_o, done_o}, 6'b0);
        chk("t6_rst_ready", ready_o, 1'b1);
        chk("t6_rst_addr", {rs1_o, rd_o}, 10'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_held_nowe", {shft_o, we_o}, 2'b00);
        @(negedge clk);
        rst_in = 1'b1;
        accept(1'b0, 1'b1, 5'd6, 5'd7, 5'd8);
        clr_tally();
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            tally();
            if (k == 1) chk("t6_lsb_first", lsb_o, 1'b1);
            if (k == 16) chk("t6_msb_16", msb_o, 1'b1);
        end
        chk("t6_nshft", n_shft, 16);
        chk("t6_nlsb", n_lsb, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_done", done_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fazyrv_rf_seq.md
# fazyrv_rf_seq

Chunk sequencer directly upstream of the chunk-serial register file. Accepts an operand/destination request, latches the register addresses, and generates per-cycle shift and write strobes for 32/CHUNKSIZE chunks. It also flags the LSB and MSB chunks for the ALU. For custom (ccx) instructions it shifts the operands out first, then writes the destination chunk-by-chunk as results arrive.

## Interface
Parameters:
- CHUNKSIZE, 2, data path width in bits; legal values 1, 2, 4, 8; N = 32/CHUNKSIZE chunks per word

Ports:
- clk_i  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- start_i  in  1  request valid
- ready_o  out  1  sequencer idle, request accepted when start_i & ready_o
- ccx_i  in  1  request is a custom instruction (sampled at accept)
- wr_i  in  1  request writes rd (sampled at accept)
- rs1_i / rs2_i / rd_i  in  5 each  register addresses (sampled at accept)
- stall_i  in  1  freeze shifting in RUN
- res_vld_i  in  1  one ccx result chunk valid on res_i this cycle
- rs1_o / rs2_o / rd_o  out  5 each  latched addresses to the regfile
- shft_o  out  1  shift all registers one chunk
- shft_rd_o  out  1  shift destination only (ccx result phase)
- we_o  out  1  write res_i into rd this cycle
- lsb_o / msb_o  out  1 each  current shift cycle is chunk 0 / chunk N-1
- done_o  out  1  one-cycle pulse after the final chunk

## Operation
- States: IDLE, RUN, WAIT_RES, DONE; counter cnt of width $clog2(N).
- IDLE: ready_o=1; on start_i latch ccx, wr, rs1, rs2, rd; cnt←0; → RUN.
- RUN: shft_o = !stall_i; cnt increments on each shift. we_o = shft_o & wr & !ccx & (rd≠0).
  - Shift with cnt=N-1 → DONE if !ccx, else → WAIT_RES with cnt←0.
- WAIT_RES: shft_o=0. On res_vld_i: shft_rd_o=1, we_o = wr & (rd≠0), cnt++.
  - Valid with cnt=N-1 → DONE. No res_vld_i: hold with no strobes.
- DONE: done_o=1 for exactly one cycle, no strobes → IDLE.
- lsb_o = strobe cycle & cnt==0; msb_o = strobe cycle & cnt==N-1. Strobe cycle = shft_o | shft_rd_o.
- rd=0: shifts occur normally; we_o is never asserted.
- start_i outside IDLE is ignored; no queueing.
- stall_i is ignored outside RUN. res_vld_i is ignored outside WAIT_RES.
- cnt wraps to 0 on completion and never exceeds N-1.

## Timing
- Reset (async assert, sync release): state IDLE, cnt 0, latched fields 0.
  - Outputs under reset: ready_o=1; all strobes, lsb_o, msb_o, done_o = 0; rs*/rd_o = 0.
- All strobes are decoded from registered state/cnt plus the same-cycle stall_i/res_vld_i. There are no other combinational input paths.
- Non-ccx, no stall: accept at T; shift cycles T+1..T+N; done_o at T+N+1; ready_o at T+N+2. Minimum start-to-start is N+2 cycles.
- Each stall cycle in RUN adds one cycle. lsb_o/msb_o stay low while stalled.
- ccx: N operand shifts, then one cycle per res_vld_i. done_o follows the cycle with the Nth valid.
- Reset mid-operation: abort immediately, with no partial writes after reset assertion.

## Structure
- The shared package fazyrv_pkg holds:
  - the state enum type rf_seq_state_t;
  - the function chunks(CHUNKSIZE) returning 32/CHUNKSIZE;
  - the constant REG_ZERO = 5'd0.
- One sub-module: fazyrv_chunk_cnt, an enabled counter with clear that outputs first/last flags. It is reused by other chunk-serial stages.
- Add an elaboration-time check for legal CHUNKSIZE.

## Test plan
- CHUNKSIZE=2, start rs1=3 rs2=4 rd=5 wr=1 ccx=0 → 16 consecutive shft_o and we_o; lsb_o in the first strobe cycle, msb_o in the 16th; done_o at T+17; ready_o at T+18.
- Same request with rd=0 → 16 shft_o, we_o never high, done_o at T+17.
- stall_i held high for 3 cycles at chunk 7 → shifting pauses with cnt at 7; done_o at T+20; exactly 16 shifts total.
- ccx=1 rd=9, res_vld_i every other cycle → 16 operand shifts with we_o=0, then 16 cycles with shft_rd_o and we_o; shft_o stays low; done_o after the 16th valid.
- start_i pulsed while in RUN, with different addresses → ignored; rs1_o/rd_o unchanged.
- rst_in low at chunk 10 → all strobes drop asynchronously; ready_o=1. A new request after release runs the full 16 chunks from cnt=0.
